rvc_asap_5pl_fpga_in: RTL

FPGA board-input conditioning stage that sits directly upstream of the core's control-register memory. It takes the raw, asynchronous push-button and slide-switch pins and runs each bit through a 2-flop synchronizer and a per-bit debounce counter. It drives clean, glitch-free levels into the CR memory's `Button_0`, `Button_1` and `Switch` inputs, and also produces one-cycle press pulses for the buttons.

---
 rtl/rvc_asap_5pl_fpga_in.sv | 116 +++++++++++
 1 files changed

// File: rtl/rvc_asap_5pl_fpga_in.sv
// rvc_asap_5pl_fpga_in: conditions the raw board push-buttons and slide
// switches before they reach the control-register memory. Each of the 12
// channels (Button_0, Button_1, Switch[9:0]) is passed through a 2-flop
// synchronizer and then a per-bit debounce counter. The accepted level drives
// the outputs directly from flops. Buttons also get a registered one-cycle
// press pulse on each accepted 0->1 transition.
//
// Optional feature macro: RVC_ASAP_DEBOUNCE_EN. When it is defined, a channel
// accepts a new level only after the synchronized value has differed from the
// accepted level for DB_LIMIT consecutive cycles. When it is undefined, the
// counters are not built and the accepted level simply follows the
// synchronizer output one cycle later.
//
// There is no handshake. Every output is a plain level, or a one-cycle
// pulse, and is valid on every cycle after reset is released. The consumer
// may sample the outputs on any cycle.
module rvc_asap_5pl_fpga_in #(
    parameter int DB_CNT_W       = 16,
    parameter int DB_LIMIT       = 50000,
    parameter int BTN_ACTIVE_LOW = 1
) (
    input  logic       Clock,
    input  logic       Rst,
    input  logic       Button_0_raw,
    input  logic       Button_1_raw,
    input  logic [9:0] Switch_raw,
    output logic       Button_0,
    output logic       Button_1,
    output logic [9:0] Switch,
    output logic       Button_0_press,
    output logic       Button_1_press
);

    localparam int   NCH     = 12;
    localparam logic BTN_INV = (BTN_ACTIVE_LOW != 0);

    // Channel map: bit 0 = Button_0, bit 1 = Button_1, bits 11:2 = Switch[9:0].
    logic [NCH-1:0] ch_in;
    logic [NCH-1:0] s1;
    logic [NCH-1:0] s2;
    logic [NCH-1:0] stable;
    logic [NCH-1:0] stable_next;
    logic [1:0]     press;

    // DB_LIMIT must be at least 1, and DB_LIMIT-1 must fit in the counter.
    if (DB_LIMIT < 1 || 64'(DB_LIMIT) >= (64'd1 << DB_CNT_W)) begin : g_bad_cfg
        $error("rvc_asap_5pl_fpga_in: DB_LIMIT out of range for DB_CNT_W");
    end

    // Buttons are normalised so that 1 always means pressed. Switches pass through unchanged.
    assign ch_in = {Switch_raw, Button_1_raw ^ BTN_INV, Button_0_raw ^ BTN_INV};

    for (genvar i = 0; i < NCH; i++) begin : g_ch
`ifdef RVC_ASAP_DEBOUNCE_EN
        logic [DB_CNT_W-1:0] cnt;
        logic [DB_CNT_W-1:0] cnt_nxt;
        logic                lvl_nxt;

        // Count consecutive cycles of disagreement. Accept the new level when the count reaches the limit.
        always_comb begin
            lvl_nxt = stable[i];
            cnt_nxt = cnt;
            if (s2[i] == stable[i]) begin
                cnt_nxt = '0;
            end else if (cnt == DB_CNT_W'(DB_LIMIT - 1)) begin
                lvl_nxt = s2[i];
                cnt_nxt = '0;
            end else begin
                cnt_nxt = cnt + 1'b1;
            end
        end

        // Per-channel debounce counter. A reset discards any partial count.
        always_ff @(posedge Clock or posedge Rst) begin
            if (Rst) begin
                cnt <= '0;
            end else begin
                cnt <= cnt_nxt;
            end
        end

        assign stable_next[i] = lvl_nxt;
`else
        assign stable_next[i] = s2[i];
`endif
    end

    // Two-flop synchronizer and the accepted level for all channels.
    always_ff @(posedge Clock or posedge Rst) begin
        if (Rst) begin
            s1     <= '0;
            s2     <= '0;
            stable <= '0;
        end else begin
            s1     <= ch_in;
            s2     <= s1;
            stable <= stable_next;
        end
    end

    // The press pulse is registered. It rises on the same edge as the accepted button level.
    always_ff @(posedge Clock or posedge Rst) begin
        if (Rst) begin
            press <= '0;
        end else begin
            press <= stable_next[1:0] & ~stable[1:0];
        end
    end

    assign Button_0       = stable[0];
    assign Button_1       = stable[1];
    assign Switch         = stable[11:2];
    assign Button_0_press = press[0];
    assign Button_1_press = press[1];

endmodule
